// File: rtl/if_stage_ifid.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Fetches from a synchronous instruction memory with a 1-cycle read latency.
// A 1-entry skid buffer holds a response that arrives while decode is stalled.
// An EX redirect flushes the front end. A misaligned redirect target produces a
// single address-error marker slot, and fetch then halts until the next redirect.
module if_stage_ifid #(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter logic [31:0] NOP_INSTR = 32'h03400000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic        id_valid_o,
  output logic        id_adef_o
);

  logic [31:0] pc_f;
  logic [31:0] req_pc;
  logic        req_v;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        skid_v;
  logic        halt_q;
  logic        adef_pend;

  logic        issue;
  logic        misaligned;
  logic        ifid_load;
  logic        load_adef;

  // Fetch issue decision and IF/ID load qualifiers.
  // NOTE: each always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    issue      = 1'b0;
    misaligned = 1'b0;
    ifid_load  = 1'b0;
    load_adef  = 1'b0;
    issue      = ~rst & ~redirect_i & ~halt_q & ~skid_v & ~(stall_i & req_v);
    misaligned = (redirect_pc_i[1:0] != 2'b00);
    ifid_load  = ~redirect_i & ~stall_i;
    load_adef  = ifid_load & ~skid_v & ~req_v & adef_pend;
  end

  assign imem_en   = issue;
  assign imem_addr = pc_f;

  // Fetch PC, outstanding-request tracking and misaligned-target halt.
  // NOTE: sequential state uses non-blocking assignments only, so every block samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f      <= RESET_PC;
      req_v     <= 1'b0;
      req_pc    <= 32'h0;
      halt_q    <= 1'b0;
      adef_pend <= 1'b0;
    end else if (redirect_i) begin
      pc_f      <= redirect_pc_i;
      req_v     <= 1'b0;
      halt_q    <= misaligned;
      adef_pend <= misaligned;
    end else begin
      if (issue) begin
        pc_f   <= pc_f + 32'd4;
        req_v  <= 1'b1;
        req_pc <= pc_f;
      end else begin
        req_v  <= 1'b0;
      end
      if (load_adef) adef_pend <= 1'b0;
    end
  end

  // Skid buffer: capture the response that arrives while decode is stalled.
  // NOTE: the skid payload is reset along with its valid bit; it is only two words, and a reset keeps the state deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_v     <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
    end else if (redirect_i) begin
      skid_v     <= 1'b0;
    end else if (stall_i) begin
      if (req_v) begin
        skid_v     <= 1'b1;
        skid_instr <= imem_rdata;
        skid_pc    <= req_pc;
      end
    end else if (skid_v) begin
      skid_v     <= 1'b0;
    end
  end

  // IF/ID register: flush on redirect, hold on stall, otherwise load by priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_o <= 1'b0;
      id_adef_o  <= 1'b0;
      id_pc_o    <= 32'h0;
      id_instr_o <= NOP_INSTR;
    end else if (redirect_i) begin
      id_valid_o <= 1'b0;
      id_adef_o  <= 1'b0;
      id_instr_o <= NOP_INSTR;
    end else if (ifid_load) begin
      if (skid_v) begin
        id_valid_o <= 1'b1;
        id_adef_o  <= 1'b0;
        id_pc_o    <= skid_pc;
        id_instr_o <= skid_instr;
      end else if (req_v) begin
        id_valid_o <= 1'b1;
        id_adef_o  <= 1'b0;
        id_pc_o    <= req_pc;
        id_instr_o <= imem_rdata;
      end else if (adef_pend) begin
        id_valid_o <= 1'b1;
        id_adef_o  <= 1'b1;
        id_pc_o    <= pc_f;
        id_instr_o <= NOP_INSTR;
      end else begin
        id_valid_o <= 1'b0;
        id_adef_o  <= 1'b0;
        id_instr_o <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_if_stage_ifid.sv
// Directed bench for if_stage_ifid: a table of per-cycle vectors covering
// sequential fetch, stall with skid, redirect under stall, misaligned redirect
// and PC wrap, followed by a hand-written asynchronous reset sequence.
module tb_if_stage_ifid;

  localparam logic [31:0] RESET_PC  = 32'h1c000000;
  localparam logic [31:0] NOP_INSTR = 32'h03400000;

  logic        clk;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_valid_o;
  logic        id_adef_o;

  int checks;
  int failures;

  if_stage_ifid #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_instr_o    (id_instr_o),
    .id_pc_o       (id_pc_o),
    .id_valid_o    (id_valid_o),
    .id_adef_o     (id_adef_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word returned for a given address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_5a5a;
  endfunction

  // Synchronous instruction memory with a 1-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= instr_of(imem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The skid buffer and the in-flight response must never coexist.
  always @(negedge clk) begin
    if (rst === 1'b0) check("skid_req_excl", {31'b0, dut.skid_v & dut.req_v}, 32'h0);
  end

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        en;
    logic [31:0] addr;
    logic        v;
    logic        adef;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic en, input logic [31:0] addr,
                              input logic v, input logic adef, input logic [31:0] pc);
    vec_t r;
    r.st = st; r.rd = rd; r.rpc = rpc; r.en = en; r.addr = addr;
    r.v = v; r.adef = adef; r.pc = pc;
    return r;
  endfunction

  initial begin
    logic [31:0] exp_instr;
    logic        seen;
    checks   = 0;
    failures = 0;

    //            st  rd  rpc           en  addr          v   adef pc
    vecs[0]  = mk(0,  0,  32'h0,        1,  32'h1c000000, 0,  0,   32'h0);
    vecs[1]  = mk(0,  0,  32'h0,        1,  32'h1c000004, 1,  0,   32'h1c000000);
    vecs[2]  = mk(0,  0,  32'h0,        1,  32'h1c000008, 1,  0,   32'h1c000004);
    vecs[3]  = mk(0,  0,  32'h0,        1,  32'h1c00000c, 1,  0,   32'h1c000008);
    // three-cycle stall: 08 held, 0c parked in the skid
    vecs[4]  = mk(1,  0,  32'h0,        0,  32'h1c000010, 1,  0,   32'h1c000008);
    vecs[5]  = mk(1,  0,  32'h0,        0,  32'h1c000010, 1,  0,   32'h1c000008);
    vecs[6]  = mk(1,  0,  32'h0,        0,  32'h1c000010, 1,  0,   32'h1c000008);
    vecs[7]  = mk(0,  0,  32'h0,        0,  32'h1c000010, 1,  0,   32'h1c00000c);
    vecs[8]  = mk(0,  0,  32'h0,        1,  32'h1c000010, 0,  0,   32'h0);
    vecs[9]  = mk(0,  0,  32'h0,        1,  32'h1c000014, 1,  0,   32'h1c000010);
    vecs[10] = mk(0,  0,  32'h0,        1,  32'h1c000018, 1,  0,   32'h1c000014);
    // fill the skid, then redirect while still stalled
    vecs[11] = mk(1,  0,  32'h0,        0,  32'h1c00001c, 1,  0,   32'h1c000014);
    vecs[12] = mk(1,  1,  32'h1c000100, 0,  32'h1c00001c, 0,  0,   32'h0);
    vecs[13] = mk(0,  0,  32'h0,        1,  32'h1c000100, 0,  0,   32'h0);
    vecs[14] = mk(0,  0,  32'h0,        1,  32'h1c000104, 1,  0,   32'h1c000100);
    vecs[15] = mk(0,  0,  32'h0,        1,  32'h1c000108, 1,  0,   32'h1c000104);
    // misaligned redirect: one adef slot, then halted
    vecs[16] = mk(0,  1,  32'h1c000102, 0,  32'h1c00010c, 0,  0,   32'h0);
    vecs[17] = mk(0,  0,  32'h0,        0,  32'h1c000102, 1,  1,   32'h1c000102);
    vecs[18] = mk(0,  0,  32'h0,        0,  32'h1c000102, 0,  0,   32'h0);
    vecs[19] = mk(0,  0,  32'h0,        0,  32'h1c000102, 0,  0,   32'h0);
    vecs[20] = mk(0,  1,  32'h1c000200, 0,  32'h1c000102, 0,  0,   32'h0);
    vecs[21] = mk(0,  0,  32'h0,        1,  32'h1c000200, 0,  0,   32'h0);
    vecs[22] = mk(0,  0,  32'h0,        1,  32'h1c000204, 1,  0,   32'h1c000200);
    // PC wrap
    vecs[23] = mk(0,  1,  32'hfffffffc, 0,  32'h1c000208, 0,  0,   32'h0);
    vecs[24] = mk(0,  0,  32'h0,        1,  32'hfffffffc, 0,  0,   32'h0);
    vecs[25] = mk(0,  0,  32'h0,        1,  32'h00000000, 1,  0,   32'hfffffffc);
    vecs[26] = mk(0,  0,  32'h0,        1,  32'h00000004, 1,  0,   32'h00000000);

    rst           = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst imem_en",  {31'b0, imem_en},    32'h0);
    check("rst valid",    {31'b0, id_valid_o}, 32'h0);
    check("rst adef",     {31'b0, id_adef_o},  32'h0);
    check("rst pc",       id_pc_o,             32'h0);
    check("rst instr",    id_instr_o,          NOP_INSTR);
    check("rst imem_addr", imem_addr,          RESET_PC);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      stall_i       = vecs[i].st;
      redirect_i    = vecs[i].rd;
      redirect_pc_i = vecs[i].rpc;
      #1;
      check($sformatf("row%0d imem_en", i), {31'b0, imem_en}, {31'b0, vecs[i].en});
      check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].addr);
      @(posedge clk);
      #1;
      exp_instr = (vecs[i].v && !vecs[i].adef) ? instr_of(vecs[i].pc) : NOP_INSTR;
      check($sformatf("row%0d valid", i), {31'b0, id_valid_o}, {31'b0, vecs[i].v});
      check($sformatf("row%0d adef", i), {31'b0, id_adef_o}, {31'b0, vecs[i].adef});
      check($sformatf("row%0d instr", i), id_instr_o, exp_instr);
      if (vecs[i].v) check($sformatf("row%0d pc", i), id_pc_o, vecs[i].pc);
      @(negedge clk);
    end

    // Park a response in the skid, then assert reset between clock edges.
    stall_i    = 1'b1;
    redirect_i = 1'b0;
    @(posedge clk);
    #2;
    check("pre-reset skid_v", {31'b0, dut.skid_v}, 32'h1);
    rst = 1'b1;
    #1;
    check("async imem_en", {31'b0, imem_en},    32'h0);
    check("async valid",   {31'b0, id_valid_o}, 32'h0);
    check("async adef",    {31'b0, id_adef_o},  32'h0);
    check("async pc",      id_pc_o,             32'h0);
    check("async instr",   id_instr_o,          NOP_INSTR);
    check("async skid_v",  {31'b0, dut.skid_v}, 32'h0);
    check("async addr",    imem_addr,           RESET_PC);
    @(negedge clk);
    stall_i = 1'b0;
    rst     = 1'b0;

    // First valid IF/ID slot after release must be RESET_PC, two edges later.
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (id_valid_o) begin
        seen = 1'b1;
        check("post-reset edges", c, 1);
        check("post-reset pc",    id_pc_o,    RESET_PC);
        check("post-reset instr", id_instr_o, instr_of(RESET_PC));
      end
    end
    check("post-reset valid seen", {31'b0, seen}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
